// File: rtl/status_uart_tx_if.sv
// Byte push channel into the status UART transmitter FIFO.
// A byte moves on every clock where in_valid and in_ready are both high; the
// sender holds in_data/in_valid until then, and in_ready never depends on in_valid.
interface status_uart_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/status_uart_tx.sv
// 8N1 LSB-first UART transmitter with a small byte FIFO and a per-frame
// latched bit period; frames run back-to-back while the FIFO holds data.
module status_uart_tx #(
  parameter int DEPTH = 4,
  parameter int DIV_W = 16
) (
  input  logic                     clock,
  input  logic                     resetb,
  status_uart_tx_if.slave          src,
  input  logic [DIV_W-1:0]         baud_div,
  output logic                     tx,
  output logic                     busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   level,
  output logic [1:0]               fsm_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state, state_nxt;
  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [7:0]       sh, sh_nxt;
  logic [DIV_W-1:0] div, div_nxt, cnt, cnt_nxt, div_clamped;
  logic [2:0]       bit_idx, bit_idx_nxt;
  logic             tx_nxt, push, pop, bit_end;

  assign src.in_ready = (level != LVL_W'(DEPTH));
  assign push         = src.in_valid & src.in_ready;
  assign div_clamped  = (baud_div < DIV_W'(2)) ? DIV_W'(2) : baud_div;
  assign bit_end      = (cnt == div - DIV_W'(1));
  assign busy         = (state != IDLE);
  assign tx_done      = (state == STOP) && bit_end;
  assign fsm_state    = state;

  always_comb begin
    state_nxt   = state;
    sh_nxt      = sh;
    div_nxt     = div;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    tx_nxt      = tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (level != '0) begin
          pop       = 1'b1;
          sh_nxt    = mem[rd_ptr];
          div_nxt   = div_clamped;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_nxt     = '0;
          state_nxt   = DATA;
          tx_nxt      = sh[0];
          bit_idx_nxt = 3'd0;
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            sh_nxt      = {1'b0, sh[7:1]};
            tx_nxt      = sh[1];
            bit_idx_nxt = bit_idx + 3'd1;
          end
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_nxt = '0;
          // Chain straight into the next START so queued frames have no idle gap.
          if (level != '0) begin
            pop       = 1'b1;
            sh_nxt    = mem[rd_ptr];
            div_nxt   = div_clamped;
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      sh      <= '0;
      div     <= '0;
      cnt     <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      sh      <= sh_nxt;
      div     <= div_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      tx      <= tx_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= src.in_data;
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule
